// File: rtl/sdram_page_bridge_pkg.sv
// Shared constants and FSM state encoding for the SDRAM page bridge.
// One page = one full-page burst of the downstream controller.
package sdram_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 15;
  localparam int PAGE_WORDS = 512;
  localparam int CNT_W      = $clog2(PAGE_WORDS) + 1;
  localparam int RAM_AW     = $clog2(PAGE_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WREQ,
    WBURST,
    RREQ,
    RCAP,
    DRAIN
  } state_t;

endpackage

// File: rtl/sdram_page_bridge_if.sv
// Host command/stream and controller-side signals of the page bridge.
// slave = bridge side, master = host plus controller side.
interface sdram_page_bridge_if
  import sdram_pkg::*;
;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  logic              busy;
  logic              err;

  logic              ctl_rw;
  logic              ctl_rw_en;
  logic [ADDR_W-1:0] ctl_addr;
  logic              ctl_ready;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_wdata_req;
  logic [DATA_W-1:0] ctl_rdata;
  logic              ctl_rdata_valid;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr,
    input  wr_data, wr_valid,
    input  rd_ready,
    input  ctl_ready, ctl_wdata_req, ctl_rdata, ctl_rdata_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, err,
    output ctl_rw, ctl_rw_en, ctl_addr, ctl_wdata
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr,
    output wr_data, wr_valid,
    output rd_ready,
    output ctl_ready, ctl_wdata_req, ctl_rdata, ctl_rdata_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, err,
    input  ctl_rw, ctl_rw_en, ctl_addr, ctl_wdata
  );

endinterface

// File: rtl/sdram_page_bridge_ram.sv
// Simple dual-port page buffer: synchronous write, registered read (one cycle).
// No reset on the array or read register so it maps onto a single block RAM.
module page_ram #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdram_page_bridge.sv
// Buffers one 512-word page between host valid/ready streams and the controller's unstallable bursts.
// Controller side never stalls; host read side honours rd_ready, write side takes a word per cycle in FILL.
module sdram_page_bridge
  import sdram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sdram_page_bridge_if.slave bus
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              rw_q, rw_nxt;
  logic              err_q, err_nxt;

  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              cmd_ready;
  logic              wr_ready;
  logic              rd_valid;
  logic              ctl_rw_en;

  logic              cnt_last;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_last = (cnt == CNT_W'(PAGE_WORDS - 1));
  assign cnt_inc  = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      rw_q   <= rw_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    rw_nxt    = rw_q;
    err_nxt   = err_q;
    ram_we    = 1'b0;
    ram_waddr = cnt[RAM_AW-1:0];
    ram_wdata = bus.wr_data;
    ram_raddr = cnt[RAM_AW-1:0];
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    ctl_rw_en = 1'b0;

    // Stray controller strobes are flagged and otherwise dropped.
    if (bus.ctl_wdata_req && (state != WBURST)) begin
      err_nxt = 1'b1;
    end
    if (bus.ctl_rdata_valid && (state != RCAP)) begin
      err_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        ram_raddr = '0;
        if (bus.cmd_valid) begin
          addr_nxt  = bus.cmd_addr;
          rw_nxt    = bus.cmd_rw;
          cnt_nxt   = '0;
          state_nxt = bus.cmd_rw ? RREQ : FILL;
        end
      end

      FILL: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          ram_we = 1'b1;
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = WREQ;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      // Holding the read address at 0 primes RAM[0] for the first burst beat.
      WREQ, RREQ: begin
        ram_raddr = '0;
        ctl_rw_en = bus.ctl_ready;
        if (bus.ctl_ready) begin
          state_nxt = (state == WREQ) ? WBURST : RCAP;
        end
      end

      WBURST: begin
        if (bus.ctl_wdata_req) begin
          ram_raddr = cnt_inc[RAM_AW-1:0];
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      RCAP: begin
        ram_raddr = '0;
        ram_wdata = bus.ctl_rdata;
        if (bus.ctl_rdata_valid) begin
          ram_we = 1'b1;
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      DRAIN: begin
        rd_valid = 1'b1;
        if (bus.rd_ready) begin
          ram_raddr = cnt_inc[RAM_AW-1:0];
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  page_ram #(
    .DEPTH (PAGE_WORDS),
    .DATA_W(DATA_W),
    .AW    (RAM_AW)
  ) u_page_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = (state == DRAIN) ? ram_rdata : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = err_q;
  assign bus.ctl_rw    = rw_q && (state == RREQ);
  assign bus.ctl_rw_en = ctl_rw_en;
  assign bus.ctl_addr  = addr_q;
  assign bus.ctl_wdata = (state == WBURST) ? ram_rdata : '0;

endmodule
